bsr_scan_ctrl: RTL and testbench

// - Sequences the boundary-scan chain (PCF/InstrF/MemWriteM/DataAdrM/WriteDataM/ReadDataM cells).
// - Accepts one scan command plus a full-width write vector; runs capture/shift/update on the BSR control lines.
// - Returns the vector shifted out of the chain.
// - Sits between JTAG test logic (or a debug host) and the bsr instances; owns bsr_shift, bsr_update, bsr_mode.

---
 rtl/bsr_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_bsr_scan_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsr_scan_ctrl.sv
// Boundary-scan chain sequencer: runs capture/shift/update on the BSR control lines.
// Define BSR_ABORT_EN to add the abort input that cuts a running sequence short.
module bsr_scan_ctrl #(
  parameter  int CHAIN_LEN = 161,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 tck,
  input  logic                 trst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [CHAIN_LEN-1:0] wdata,
`ifdef BSR_ABORT_EN
  input  logic                 abort,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] rdata,
  output logic                 bsr_tdi,
  input  logic                 bsr_tdo,
  output logic                 bsr_shift,
  output logic                 bsr_update,
  output logic                 bsr_mode
);

  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_SHIFT, S_UPDATE, S_DONE} state_e;
  typedef enum logic [1:0] {OP_SAMPLE = 2'd0, OP_PRELOAD = 2'd1,
                            OP_EXTEST = 2'd2, OP_RELEASE = 2'd3} op_e;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [CHAIN_LEN-1:0] wdata_q, wdata_d;
  logic [CHAIN_LEN-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 mode_q, mode_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 shift_q, shift_d;
  logic                 update_q, update_d;
  logic                 tdi_q, tdi_d;
  logic                 abort_hit;

`ifdef BSR_ABORT_EN
  assign abort_hit = abort && (state_q inside {S_CAPTURE, S_SHIFT, S_UPDATE});
`else
  assign abort_hit = 1'b0;
`endif

  // NOTE: every signal gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op_e'(op);
          wdata_d = wdata;
          unique case (op_e'(op))
            OP_SAMPLE, OP_EXTEST: state_d = S_CAPTURE;
            OP_PRELOAD:           state_d = S_SHIFT;
            default: begin
              state_d = S_DONE;
              mode_d  = 1'b0;
            end
          endcase
        end
      end
      S_CAPTURE: state_d = S_SHIFT;
      S_SHIFT: begin
        rdata_d[cnt_q] = bsr_tdo;
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = (op_q == OP_SAMPLE) ? S_DONE : S_UPDATE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_UPDATE: begin
        if (op_q == OP_EXTEST) mode_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // An abort skips UPDATE entirely, so the core/memory ownership never changes.
    if (abort_hit) begin
      state_d = S_DONE;
      cnt_d   = '0;
      mode_d  = mode_q;
    end

    // Outputs are decoded from the next state and registered, so they change only on tck.
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    shift_d  = (state_d == S_SHIFT);
    update_d = (state_d == S_UPDATE);
    tdi_d    = (state_d == S_SHIFT) ? wdata_d[cnt_d] : 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_SAMPLE;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      shift_q  <= 1'b0;
      update_q <= 1'b0;
      tdi_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      shift_q  <= shift_d;
      update_q <= update_d;
      tdi_q    <= tdi_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rdata      = rdata_q;
  assign bsr_tdi    = tdi_q;
  assign bsr_shift  = shift_q;
  assign bsr_update = update_q;
  assign bsr_mode   = mode_q;

endmodule

// File: tb/tb_bsr_scan_ctrl.sv
// Bench for bsr_scan_ctrl: 8-cell chain stub with a per-cycle reference model,
// directed cases, randomized commands, and a 161-cell smoke run.
`timescale 1ns/1ps
module tb_bsr_scan_ctrl;
  localparam int N  = 8;
  localparam int NB = 161;
  localparam logic [1:0] OP_SAMPLE = 2'd0, OP_PRELOAD = 2'd1, OP_EXTEST = 2'd2, OP_RELEASE = 2'd3;

  logic tck = 1'b0, trst = 1'b0;
  logic start = 1'b0;
  logic [1:0] op = 2'd0;
  logic [N-1:0] wdata = '0;
  logic busy, done, bsr_tdi, bsr_tdo, bsr_shift, bsr_update, bsr_mode;
  logic [N-1:0] rdata;
  logic [N-1:0] par_in = '0, chain = '0, upd = '0;

  logic start_b = 1'b0;
  logic [1:0] op_b = 2'd0;
  logic [NB-1:0] wdata_b = '0;
  logic busy_b, done_b, tdi_b, tdo_b, shift_b, update_b, mode_b;
  logic [NB-1:0] rdata_b;
  logic [NB-1:0] par_b = '0, chain_b = '0, upd_b = '0;
`ifdef BSR_ABORT_EN
  logic abort = 1'b0;
  logic abort_b = 1'b0;
`endif

  int n_tests = 0, n_fail = 0;
  bit chk_en = 1'b0;

  always #5 tck = ~tck;

  bsr_scan_ctrl #(.CHAIN_LEN(N)) u_dut (
    .tck(tck), .trst(trst), .start(start), .op(op), .wdata(wdata),
`ifdef BSR_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .rdata(rdata), .bsr_tdi(bsr_tdi), .bsr_tdo(bsr_tdo),
    .bsr_shift(bsr_shift), .bsr_update(bsr_update), .bsr_mode(bsr_mode)
  );

  bsr_scan_ctrl u_big (
    .tck(tck), .trst(trst), .start(start_b), .op(op_b), .wdata(wdata_b),
`ifdef BSR_ABORT_EN
    .abort(abort_b),
`endif
    .busy(busy_b), .done(done_b), .rdata(rdata_b), .bsr_tdi(tdi_b), .bsr_tdo(tdo_b),
    .bsr_shift(shift_b), .bsr_update(update_b), .bsr_mode(mode_b)
  );

  // Chain stubs: cells capture parallel_in whenever not shifting; update latches the chain.
  assign bsr_tdo = chain[N-1];
  always @(posedge tck) begin
    chain <= bsr_shift ? {chain[N-2:0], bsr_tdi} : par_in;
    if (bsr_update) upd <= chain;
  end

  assign tdo_b = chain_b[NB-1];
  always @(posedge tck) begin
    chain_b <= shift_b ? {chain_b[NB-2:0], tdi_b} : par_b;
    if (update_b) upd_b <= chain_b;
  end

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [191:0] rev(input logic [191:0] v, input int n);
    logic [191:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = v[n-1-i];
    return r;
  endfunction

  function automatic int lat_of(input logic [1:0] o);
    case (o)
      OP_SAMPLE:  return N + 2;
      OP_PRELOAD: return N + 2;
      OP_EXTEST:  return N + 3;
      default:    return 1;
    endcase
  endfunction

  // Reference model: a command is a timeline of m_len cycles; m_k is the cycle index since accept.
  logic [1:0]   m_op = 2'd0;
  logic [N-1:0] m_w = '0, m_rdata = '0;
  int           m_len = 0, m_k = 0;
  logic         m_mode = 1'b0;

  always @(posedge tck or negedge trst) begin
    if (!trst) begin
      m_len <= 0; m_k <= 0; m_mode <= 1'b0; m_rdata <= '0;
    end else if (m_len == 0) begin
      if (start) begin
        m_op <= op; m_w <= wdata; m_len <= lat_of(op); m_k <= 1;
        if (op == OP_RELEASE) m_mode <= 1'b0;
      end
    end else if (m_k == m_len) begin
      m_len <= 0; m_k <= 0;
    end else begin
      m_k <= m_k + 1;
      if (m_k + 1 == m_len) begin
        if (m_op == OP_EXTEST) m_mode <= 1'b1;
        m_rdata <= N'(rev(192'(par_in), N));
      end
    end
  end

  int   s0;
  logic e_busy, e_done, e_shift, e_upd;
  always @(negedge tck) begin
    if (trst && chk_en) begin
      s0      = (m_op == OP_PRELOAD) ? 1 : 2;
      e_busy  = (m_len != 0);
      e_done  = e_busy && (m_k == m_len);
      e_shift = e_busy && (m_op != OP_RELEASE) && (m_k >= s0) && (m_k < s0 + N);
      e_upd   = e_busy && (m_op == OP_EXTEST || m_op == OP_PRELOAD) && (m_k == m_len - 1);
      check("busy", 192'(busy), 192'(e_busy));
      check("done", 192'(done), 192'(e_done));
      check("bsr_shift", 192'(bsr_shift), 192'(e_shift));
      check("bsr_update", 192'(bsr_update), 192'(e_upd));
      check("bsr_mode", 192'(bsr_mode), 192'(m_mode));
      if (e_shift) check("bsr_tdi", 192'(bsr_tdi), 192'(m_w[m_k-s0]));
      if (!e_busy || e_done) check("rdata", 192'(rdata), 192'(m_rdata));
      if (e_done && (m_op == OP_EXTEST || m_op == OP_PRELOAD))
        check("chain_update", 192'(upd), rev(192'(m_w), N));
    end
  end

  // Issue one command and measure it; spam keeps start high with random op/wdata through DONE.
  task automatic run_cmd(input logic [1:0] o, input logic [N-1:0] w, input bit spam,
                         output int lat, output int nsh, output int nup, output int nex);
    lat = 0; nsh = 0; nup = 0; nex = 0;
    @(negedge tck);
    start = 1'b1; op = o; wdata = w;
    for (int c = 1; c <= 200 && lat == 0; c++) begin
      @(negedge tck);
      if (spam) begin
        op = 2'($urandom); wdata = N'($urandom);
      end else begin
        start = 1'b0;
      end
      nsh += int'(bsr_shift);
      nup += int'(bsr_update);
      if (done) lat = c;
    end
    if (lat == 0) check("done_timeout", 192'(0), 192'(1));
    repeat (3) begin
      @(negedge tck);
      start = 1'b0;
      nex += int'(done);
    end
  endtask

  initial begin
    int lat, nsh, nup, nex;
    logic [1:0] o;
    bit sp;
    logic m0;

    repeat (2) @(negedge tck);
    check("rst_busy", 192'(busy), 192'(0));
    check("rst_done", 192'(done), 192'(0));
    check("rst_shift", 192'(bsr_shift), 192'(0));
    check("rst_update", 192'(bsr_update), 192'(0));
    check("rst_mode", 192'(bsr_mode), 192'(0));
    check("rst_tdi", 192'(bsr_tdi), 192'(0));
    check("rst_rdata", 192'(rdata), 192'(0));
    #2 trst = 1'b1;
    chk_en = 1'b1;

    par_in = 8'hA5;
    run_cmd(OP_SAMPLE, 8'h00, 1'b0, lat, nsh, nup, nex);
    check("sample_latency", 192'(lat), 192'(10));
    check("sample_rdata", 192'(rdata), 192'(8'hA5));
    check("sample_shifts", 192'(nsh), 192'(8));
    check("sample_no_update", 192'(nup), 192'(0));
    check("sample_mode", 192'(bsr_mode), 192'(0));

    run_cmd(OP_EXTEST, 8'h3C, 1'b0, lat, nsh, nup, nex);
    check("extest_latency", 192'(lat), 192'(11));
    check("extest_shifts", 192'(nsh), 192'(8));
    check("extest_updates", 192'(nup), 192'(1));
    check("extest_chain", 192'(upd), 192'(8'h3C));
    check("extest_mode", 192'(bsr_mode), 192'(1));

    // Reset in the middle of SHIFT (cycle 4 after accept).
    @(negedge tck);
    start = 1'b1; op = OP_EXTEST; wdata = 8'h55;
    @(negedge tck);
    start = 1'b0;
    repeat (3) @(negedge tck);
    check("pre_rst_shift", 192'(bsr_shift), 192'(1));
    #2 trst = 1'b0;
    #1;
    check("midrst_shift", 192'(bsr_shift), 192'(0));
    check("midrst_mode", 192'(bsr_mode), 192'(0));
    check("midrst_busy", 192'(busy), 192'(0));
    check("midrst_rdata", 192'(rdata), 192'(0));
    @(negedge tck);
    #2 trst = 1'b1;
    run_cmd(OP_SAMPLE, 8'h00, 1'b0, lat, nsh, nup, nex);
    check("post_rst_latency", 192'(lat), 192'(10));

    run_cmd(OP_EXTEST, 8'h3C, 1'b1, lat, nsh, nup, nex);
    check("spam_latency", 192'(lat), 192'(11));
    check("spam_shifts", 192'(nsh), 192'(8));
    check("spam_updates", 192'(nup), 192'(1));
    check("spam_extra_done", 192'(nex), 192'(0));

    run_cmd(OP_PRELOAD, 8'hFF, 1'b0, lat, nsh, nup, nex);
    check("preload_latency", 192'(lat), 192'(10));
    check("preload_mode_kept", 192'(bsr_mode), 192'(1));
    check("preload_chain", 192'(upd), 192'(8'hFF));
    run_cmd(OP_RELEASE, 8'h00, 1'b0, lat, nsh, nup, nex);
    check("release_latency", 192'(lat), 192'(1));
    check("release_shifts", 192'(nsh), 192'(0));
    check("release_mode", 192'(bsr_mode), 192'(0));

    for (int t = 0; t < 40; t++) begin
      par_in = N'($urandom);
      o = 2'($urandom);
      sp = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) @(negedge tck);
      run_cmd(o, N'($urandom), sp, lat, nsh, nup, nex);
      check("rand_latency", 192'(lat), 192'(lat_of(o)));
      check("rand_extra_done", 192'(nex), 192'(0));
    end

`ifdef BSR_ABORT_EN
    chk_en = 1'b0;
    m0 = bsr_mode;
    @(negedge tck);
    start = 1'b1; op = OP_EXTEST; wdata = 8'h0F;
    @(negedge tck);
    start = 1'b0;
    nup = 0;
    repeat (3) begin @(negedge tck); nup += int'(bsr_update); end
    abort = 1'b1;
    @(negedge tck);
    abort = 1'b0;
    check("abort_done", 192'(done), 192'(1));
    check("abort_shift_off", 192'(bsr_shift), 192'(0));
    repeat (3) begin @(negedge tck); nup += int'(bsr_update); end
    check("abort_no_update", 192'(nup), 192'(0));
    check("abort_mode", 192'(bsr_mode), 192'(m0));
    check("abort_idle", 192'(busy), 192'(0));
`else
    m0 = 1'b0;
`endif

    for (int i = 0; i < NB; i++) begin
      par_b[i]   = 1'($urandom_range(0, 1));
      wdata_b[i] = 1'($urandom_range(0, 1));
    end
    @(negedge tck);
    start_b = 1'b1; op_b = OP_EXTEST;
    @(negedge tck);
    start_b = 1'b0;
    lat = 0;
    for (int c = 2; c <= 400 && lat == 0; c++) begin
      @(negedge tck);
      if (done_b) lat = c;
    end
    check("big_latency", 192'(lat), 192'(NB + 3));
    check("big_rdata", 192'(rdata_b), rev(192'(par_b), NB));
    check("big_chain", 192'(upd_b), rev(192'(wdata_b), NB));
    check("big_mode", 192'(mode_b), 192'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
